// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller: state encoding,
// default key codes and the LED status pattern helper.
package game_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_START = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } game_state_e;

    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_SPACE = 9'h029;

    // Pattern is built 64 bits wide; callers truncate to their bus width.
    function automatic logic [63:0] led_pattern(
        input game_state_e s,
        input int unsigned w
    );
        logic [63:0] ones;
        logic [63:0] pat;
        ones = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        pat  = '0;
        unique case (s)
            ST_START: pat = '0;
            ST_PLAY:  pat = 64'd1;
            ST_PAUSE: pat = 64'd1 | (64'd1 << (w - 1));
            ST_WIN:   pat = (64'd1 << (w / 2)) - 64'd1;
            ST_LOSE:  pat = ones;
            default:  pat = '0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Single-clock game-second tick: one-cycle pulse every TICK_CYCLES
// enabled cycles, counter frozen while disabled.
module game_tick_gen #(
    parameter int unsigned TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow controller: START/PLAY/PAUSE/WIN/LOSE FSM with time limit,
// qualified distance hits and a best-winning-time record.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 100_000_000,
    parameter int unsigned SEC_W       = 10,
    parameter int unsigned TIME_LIMIT  = 300,
    parameter int unsigned DIST_W      = 20,
    parameter int unsigned DIST_THRESH = 50,
    parameter int unsigned HIT_COUNT   = 4,
    parameter logic [8:0]  START_CODE  = KEY_ENTER,
    parameter logic [8:0]  PAUSE_CODE  = KEY_SPACE,
    parameter int unsigned LED_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [8:0]        key_code,
    input  logic              key_pressed,
    input  logic [DIST_W-1:0] distance,
    input  logic              dist_valid,
    output logic [2:0]        state,
    output logic [SEC_W-1:0]  sec,
    output logic [SEC_W-1:0]  best_sec,
    output logic              win_pulse,
    output logic              lose_pulse,
    output logic [LED_W-1:0]  led
);

    localparam int unsigned HW = $clog2(HIT_COUNT + 1);
    localparam logic [HW-1:0]     HIT_MAX = HW'(HIT_COUNT);
    localparam logic [SEC_W-1:0]  SEC_MAX = SEC_W'(TIME_LIMIT);
    localparam logic [DIST_W-1:0] THRESH  = DIST_W'(DIST_THRESH);

    game_state_e      state_q;
    game_state_e      state_d;
    logic [SEC_W-1:0] sec_q;
    logic [SEC_W-1:0] sec_d;
    logic [SEC_W-1:0] best_q;
    logic [HW-1:0]    hit_q;
    logic [HW-1:0]    hit_d;
    logic             start_ev;
    logic             pause_ev;
    logic             is_hit;
    logic             tick;
    logic             win_entry;
    logic             lose_entry;
    logic             win_q;
    logic             lose_q;
    logic [LED_W-1:0] led_q;

    assign start_ev = key_valid && key_pressed && (key_code == START_CODE);
    assign pause_ev = key_valid && key_pressed && (key_code == PAUSE_CODE);
    assign is_hit   = distance < THRESH;

    // Clearing on the START entry edge makes sec read 0 as soon as START shows.
    game_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == ST_PLAY),
        .clear  (state_d == ST_START),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_START: begin
                if (start_ev) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (sec_q == SEC_MAX)      state_d = ST_LOSE;
                else if (hit_q == HIT_MAX) state_d = ST_WIN;
                else if (pause_ev)         state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_ev)      state_d = ST_PLAY;
                else if (start_ev) state_d = ST_START;
            end
            ST_WIN, ST_LOSE: begin
                if (start_ev) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase
    end

    always_comb begin
        sec_d = sec_q;
        hit_d = hit_q;
        if (state_d == ST_START) begin
            sec_d = '0;
            hit_d = '0;
        end else begin
            if (tick && (sec_q != SEC_MAX)) sec_d = sec_q + SEC_W'(1);
            if ((state_q == ST_PLAY) && dist_valid) begin
                if (!is_hit)               hit_d = '0;
                else if (hit_q != HIT_MAX) hit_d = hit_q + HW'(1);
            end
        end
    end

    assign win_entry  = (state_d == ST_WIN)  && (state_q != ST_WIN);
    assign lose_entry = (state_d == ST_LOSE) && (state_q != ST_LOSE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_START;
            sec_q   <= '0;
            hit_q   <= '0;
            best_q  <= '1;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            hit_q   <= hit_d;
            win_q   <= win_entry;
            lose_q  <= lose_entry;
            led_q   <= LED_W'(led_pattern(state_d, LED_W));
            if (win_entry && (sec_d < best_q)) best_q <= sec_d;
        end
    end

    assign state      = state_q;
    assign sec        = sec_q;
    assign best_sec   = best_q;
    assign win_pulse  = win_q;
    assign lose_pulse = lose_q;
    assign led        = led_q;

endmodule
